// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter (LSB first) with valid/ready byte intake.
//               Define UART_TX_PARITY_EN to insert an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int CLK_FREQUENCY  = 66_000_000,
  parameter int UART_FREQUENCY = 921_600,
  parameter int STOP_BITS      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       busy,
  output logic       tx
);

  localparam int          TICKS_PER_BIT = CLK_FREQUENCY / UART_FREQUENCY;
  localparam logic [14:0] c_tick_last   = 15'(TICKS_PER_BIT - 1);
  localparam logic [2:0]  c_stop_last   = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t      r_state;
  logic [7:0]  r_shift;
  logic [14:0] r_tick;
  logic [2:0]  r_bit;
  logic        r_tx;
  logic        w_tick_last;
`ifdef UART_TX_PARITY_EN
  logic        r_parity;
`endif

  assign w_tick_last = (r_tick == c_tick_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shift  <= 8'd0;
      r_tick   <= 15'd0;
      r_bit    <= 3'd0;
      r_tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      // tick free-runs in every non-idle state and wraps on the last tick of a bit
      if (r_state != S_IDLE) begin
        r_tick <= w_tick_last ? 15'd0 : r_tick + 15'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (valid) begin
            r_shift  <= data;
            r_tick   <= 15'd0;
            r_bit    <= 3'd0;
            r_state  <= S_START;
            r_tx     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^data;
`endif
          end
        end

        S_START: begin
          if (w_tick_last) begin
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end
        end

        S_DATA: begin
          if (w_tick_last) begin
            if (r_bit == 3'd7) begin
              r_bit   <= 3'd0;
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_shift <= {1'b0, r_shift[7:1]};
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_tick_last) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
        end
`endif

        S_STOP: begin
          // r_bit is reused to count stop bits
          if (w_tick_last) begin
            if (r_bit == c_stop_last) begin
              r_bit   <= 3'd0;
              r_state <= S_IDLE;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign ready = (r_state == S_IDLE);
  assign busy  = (r_state != S_IDLE);
  assign tx    = r_tx;

endmodule
`default_nettype wire
